// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM.
// Optional JAL support is enabled by defining MULTICYCLE_JAL_EN.
package mips_ctrl_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned ALUOP_W  = 4;
  localparam int unsigned SEL_W    = 2;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPCODE_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;

  localparam logic [ALUOP_W-1:0] ALU_RTYPE = 4'b1111;
  localparam logic [ALUOP_W-1:0] ALU_ADD   = 4'b0100;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 4'b0101;
  localparam logic [ALUOP_W-1:0] ALU_LUI   = 4'b0110;
  localparam logic [ALUOP_W-1:0] ALU_LW    = 4'b0001;
  localparam logic [ALUOP_W-1:0] ALU_SW    = 4'b0010;
  localparam logic [ALUOP_W-1:0] ALU_BR    = 4'b0011;

  localparam logic [SEL_W-1:0] REG_DST_RT = 2'b00;
  localparam logic [SEL_W-1:0] REG_DST_RD = 2'b01;
  localparam logic [SEL_W-1:0] REG_DST_RA = 2'b10;

  localparam logic [SEL_W-1:0] WB_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] WB_MDR    = 2'b01;
  localparam logic [SEL_W-1:0] WB_PC     = 2'b10;

  localparam logic [SEL_W-1:0] SRC_B_REG    = 2'b00;
  localparam logic [SEL_W-1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [SEL_W-1:0] SRC_B_IMM    = 2'b10;
  localparam logic [SEL_W-1:0] SRC_B_BR_OFF = 2'b11;

  localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JAL       = 4'd12
  } state_e;

  typedef struct packed {
    logic               pc_write;
    logic               pc_write_cond;
    logic               branch_ne;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic [SEL_W-1:0]   reg_dst;
    logic [SEL_W-1:0]   mem_to_reg;
    logic               reg_write;
    logic               alu_src_a;
    logic [SEL_W-1:0]   alu_src_b;
    logic [SEL_W-1:0]   pc_source;
    logic [ALUOP_W-1:0] alu_op;
    logic               illegal;
  } ctrl_t;

  // ALU class for the immediate-arithmetic group
  function automatic logic [ALUOP_W-1:0] imm_alu_op(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_ORI:  return ALU_OR;
      OP_LUI:  return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic is_supported(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI,
      OP_ORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
`ifdef MULTICYCLE_JAL_EN
      OP_JAL:  return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_next_state.sv
// Combinational next-state function of the multicycle main control FSM.
// JAL dispatch from DECODE exists only when MULTICYCLE_JAL_EN is defined.
module multicycle_next_state
  import mips_ctrl_pkg::*;
(
  input  state_e              state,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output state_e              state_next
);

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:     state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                state_next = S_R_EXEC;
          OP_ADDI, OP_ORI, OP_LUI: state_next = S_I_EXEC;
          OP_LW, OP_SW:            state_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:          state_next = S_BRANCH;
          OP_J:                    state_next = S_JUMP;
`ifdef MULTICYCLE_JAL_EN
          OP_JAL:                  state_next = S_JAL;
`endif
          default:                 state_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    state_next = S_R_WB;
      S_I_EXEC:    state_next = S_I_WB;
      default:     state_next = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath (Moore outputs from state).
// Define MULTICYCLE_JAL_EN to add the JAL instruction.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                branch_ne,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic [SEL_W-1:0]    reg_dst,
  output logic [SEL_W-1:0]    mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [SEL_W-1:0]    alu_src_b,
  output logic [SEL_W-1:0]    pc_source,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                illegal
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_c;

  multicycle_next_state u_next_state (
    .state      (state_q),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .state_next (state_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Output decode; reset masks everything, even while state_q sits in FETCH
  always_comb begin
    ctrl_c = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.ir_write  = mem_ready;
        ctrl_c.pc_write  = mem_ready;
        ctrl_c.alu_src_b = SRC_B_FOUR;
        ctrl_c.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        ctrl_c.alu_src_b = SRC_B_BR_OFF;
        ctrl_c.alu_op    = ALU_ADD;
        ctrl_c.illegal   = ~is_supported(opcode);
      end
      S_MEM_ADDR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRC_B_IMM;
        ctrl_c.alu_op    = (opcode == OP_SW) ? ALU_SW : ALU_LW;
      end
      S_MEM_READ: begin
        ctrl_c.i_or_d   = 1'b1;
        ctrl_c.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = WB_MDR;
        ctrl_c.reg_dst    = REG_DST_RT;
      end
      S_MEM_WRITE: begin
        ctrl_c.i_or_d    = 1'b1;
        ctrl_c.mem_write = 1'b1;
      end
      S_R_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRC_B_REG;
        ctrl_c.alu_op    = ALU_RTYPE;
      end
      S_R_WB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.reg_dst   = REG_DST_RD;
      end
      S_I_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRC_B_IMM;
        ctrl_c.alu_op    = imm_alu_op(opcode);
      end
      S_I_WB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.reg_dst   = REG_DST_RT;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.alu_op        = ALU_BR;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.pc_source     = PC_SRC_ALUOUT;
        ctrl_c.branch_ne     = opcode[0];
      end
      S_JUMP: begin
        ctrl_c.pc_write  = 1'b1;
        ctrl_c.pc_source = PC_SRC_JUMP;
      end
`ifdef MULTICYCLE_JAL_EN
      S_JAL: begin
        ctrl_c.pc_write   = 1'b1;
        ctrl_c.pc_source  = PC_SRC_JUMP;
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.reg_dst    = REG_DST_RA;
        ctrl_c.mem_to_reg = WB_PC;
      end
`endif
      default: ctrl_c = '0;
    endcase
    if (!reset) ctrl_c = '0;
  end

  assign pc_write      = ctrl_c.pc_write;
  assign pc_write_cond = ctrl_c.pc_write_cond;
  assign branch_ne     = ctrl_c.branch_ne;
  assign i_or_d        = ctrl_c.i_or_d;
  assign mem_read      = ctrl_c.mem_read;
  assign mem_write     = ctrl_c.mem_write;
  assign ir_write      = ctrl_c.ir_write;
  assign reg_dst       = ctrl_c.reg_dst;
  assign mem_to_reg    = ctrl_c.mem_to_reg;
  assign reg_write     = ctrl_c.reg_write;
  assign alu_src_a     = ctrl_c.alu_src_a;
  assign alu_src_b     = ctrl_c.alu_src_b;
  assign pc_source     = ctrl_c.pc_source;
  assign alu_op        = ctrl_c.alu_op;
  assign illegal       = ctrl_c.illegal;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath: the initiator side of the ALU control interface. It decodes the instruction opcode over several clock cycles, sequences fetch/decode/execute/memory/write-back, and drives every datapath enable plus the 4-bit ALUOp consumed by the ALU control decoder. It sits between the instruction register and the datapath muxes, register file, PC and memory port, and stalls on a simple memory-ready handshake.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  instruction bits [31:26] from instruction register
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by branch outcome (datapath ANDs with zero / ~zero)
- branch_ne  out  1  1 = BNE (qualify with ~zero), 0 = BEQ
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read / mem_write  out  1 each  memory strobes
- ir_write  out  1  load instruction register
- reg_dst  out  2  00 = rt, 01 = rd, 10 = $31
- mem_to_reg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_op  out  4  ALU control class code
- illegal  out  1  one-cycle pulse on unsupported opcode

## Operation
- alu_op codes: 1111 R-type, 0100 ADDI/add, 0101 ORI, 0110 LUI, 0001 LW, 0010 SW, 0011 BEQ/BNE.
- Opcodes: R 000000, ADDI 001000, ORI 001101, LUI 001111, LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010.
- Moore outputs, decoded from the state register; every unlisted output is 0.
- FETCH: mem_read, ir_write, alu_src_b=01, alu_op=0100, pc_write; ir_write and pc_write only when mem_ready=1; stay until mem_ready.
- DECODE: alu_src_b=11, alu_op=0100 (branch target into ALUOut); next state by opcode.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=0001 (LW) or 0010 (SW) -> MEM_READ / MEM_WRITE.
- MEM_READ: i_or_d=1, mem_read; wait on mem_ready -> MEM_WB (reg_write, mem_to_reg=01, reg_dst=00) -> FETCH.
- MEM_WRITE: i_or_d=1, mem_write; wait on mem_ready -> FETCH.
- R_EXEC: alu_src_a=1, alu_op=1111 -> R_WB (reg_write, reg_dst=01) -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op per opcode -> I_WB (reg_write, reg_dst=00) -> FETCH.
- BRANCH: alu_src_a=1, alu_op=0011, pc_write_cond, pc_source=01, branch_ne=opcode[0] -> FETCH.
- JUMP: pc_write, pc_source=10 -> FETCH.
- Unsupported opcode in DECODE: illegal=1 for that cycle, next state FETCH, no architectural write.

## Timing
- reset low: state forced to FETCH asynchronously, all outputs 0 regardless of state; applies mid-instruction too.
- First rising edge after release is a FETCH cycle.
- Cycles with zero-wait memory: branch/jump 3, R/I/SW 4, LW 5; each wait cycle (mem_ready=0) in FETCH, MEM_READ, MEM_WRITE adds one.
- mem_ready ignored outside memory states.
- Strobes mem_read/mem_write held for the whole wait; no write-enable pulses during wait except the strobes themselves.

## Configuration
- MULTICYCLE_JAL_EN defined: opcode 000011 (JAL) decoded; DECODE -> JAL state: pc_write, pc_source=10, reg_write, reg_dst=10, mem_to_reg=10 -> FETCH (3 cycles).
- Undefined: 000011 treated as unsupported (illegal pulse); reg_dst/mem_to_reg code 10 never driven.

## Structure
- Package mips_ctrl_pkg: opcode constants, alu_op class codes, state encoding enum, mux select codes.
- One sub-module multicycle_next_state: combinational next-state function (state, opcode, mem_ready); top holds the state register and output decode.

## Test plan
- reset low mid-LW (in MEM_READ) -> all outputs 0 immediately; after release state FETCH, mem_read=1.
- opcode 000000, mem_ready=1 always -> 4 cycles, alu_op=1111 in cycle 3, reg_write with reg_dst=01 in cycle 4.
- opcode 100011, mem_ready low 2 cycles in MEM_READ -> 7 cycles total, reg_write with mem_to_reg=01 in last cycle.
- opcode 000101 -> cycle 3: pc_write_cond=1, branch_ne=1, alu_op=0011, pc_source=01.
- opcode 000011 -> with macro: reg_write, reg_dst=10, pc_write in cycle 3; without: illegal pulse in cycle 2, no writes.
- opcode 001101 -> alu_op=0101 in I_EXEC, reg_dst=00 in I_WB; opcode 111111 -> illegal, back to FETCH.
